// File: rtl/text_pane_scheduler_pkg.sv
// Shared types and constants for the text pane scheduler: FSM states, plane
// geometry defaults and the control character codes it reacts to.
package text_pane_scheduler_pkg;

  localparam int ROWS_DEF     = 7;
  localparam int COLS_DEF     = 20;
  localparam int ROW_BITS_DEF = 4;
  localparam int COL_BITS_DEF = 6;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCROLL,
    ST_CLEAR
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_pane_scheduler_arb.sv
// Two-way round-robin arbiter; the requester granted last loses the next tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  logic last_q;  // 1: requester 1 was granted last

  always_comb begin
    gnt0_o = en_i & req0_i & (~req1_i | last_q);
    gnt1_o = en_i & req1_i & (~req0_i | ~last_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset)       last_q <= 1'b1;
    else if (gnt0_o) last_q <= 1'b0;
    else if (gnt1_o) last_q <= 1'b1;
  end

endmodule

// File: rtl/text_pane_scheduler.sv
// Character-plane write scheduler: arbitrates two character feeds and turns
// them into cell writes, scrolls and full-plane clears with cursor tracking.
module text_pane_scheduler
  import text_pane_scheduler_pkg::*;
#(
  parameter int ROWS     = ROWS_DEF,
  parameter int COLS     = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int COL_BITS = COL_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic [7:0]          req0_char,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic [7:0]          req1_char,
  output logic                req1_ready,
  output logic                wr_en,
  output logic [ROW_BITS-1:0] wr_row,
  output logic [COL_BITS-1:0] wr_col,
  output logic [7:0]          wr_char,
  output logic                scroll,
  output logic                busy,
  output logic [ROW_BITS-1:0] cur_row,
  output logic [COL_BITS-1:0] cur_col
);

  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

  state_e                state_q, state_d;
  logic [ROW_BITS-1:0]   row_q, row_d, clr_row_q, clr_row_d;
  logic [COL_BITS-1:0]   col_q, col_d, clr_col_q, clr_col_d;
  logic [7:0]            char_q, char_d;
  logic                  bs_q, bs_d;  // current WRITE is a backspace erase
  logic                  gnt0, gnt1, xfer;
  logic [7:0]            in_char;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .en_i   ((state_q == ST_IDLE) && !reset),
    .req0_i (req0_valid),
    .req1_i (req1_valid),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign in_char    = gnt0 ? req0_char : req1_char;
  assign cur_row    = row_q;
  assign cur_col    = col_q;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    char_d    = char_q;
    bs_d      = bs_q;
    unique case (state_q)
      ST_IDLE: if (xfer) begin
        char_d = in_char;
        bs_d   = 1'b0;
        if (is_printable(in_char)) begin
          state_d = ST_WRITE;
        end else if (in_char == CH_CR) begin
          col_d = '0;
          if (row_q < ROW_LAST) row_d   = row_q + 1'b1;
          else                  state_d = ST_SCROLL;
        end else if (in_char == CH_BS) begin
          if (col_q != '0) begin
            col_d   = col_q - 1'b1;
            bs_d    = 1'b1;
            state_d = ST_WRITE;
          end
        end else if (in_char == CH_FF) begin
          state_d = ST_CLEAR;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        if (!bs_q) begin
          if (col_q < COL_LAST) begin
            col_d = col_q + 1'b1;
          end else begin
            col_d = '0;
            if (row_q < ROW_LAST) row_d   = row_q + 1'b1;
            else                  state_d = ST_SCROLL;
          end
        end
      end
      ST_SCROLL: state_d = ST_IDLE;
      ST_CLEAR: begin
        if (clr_col_q == COL_LAST) begin
          clr_col_d = '0;
          if (clr_row_q == ROW_LAST) begin
            clr_row_d = '0;
            row_d     = '0;
            col_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            clr_row_d = clr_row_q + 1'b1;
          end
        end else begin
          clr_col_d = clr_col_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset so an aborted CLEAR/SCROLL stops immediately.
  always_comb begin
    wr_en   = 1'b0;
    wr_row  = '0;
    wr_col  = '0;
    wr_char = '0;
    scroll  = 1'b0;
    busy    = !reset && (state_q != ST_IDLE);
    if (!reset) begin
      unique case (state_q)
        ST_WRITE: begin
          wr_en   = 1'b1;
          wr_row  = row_q;
          wr_col  = col_q;
          wr_char = bs_q ? CH_SPACE : char_q;
        end
        ST_CLEAR: begin
          wr_en   = 1'b1;
          wr_row  = clr_row_q;
          wr_col  = clr_col_q;
          wr_char = CH_SPACE;
        end
        ST_SCROLL: scroll = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      clr_row_q <= '0;
      clr_col_q <= '0;
      char_q    <= '0;
      bs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
      char_q    <= char_d;
      bs_q      <= bs_d;
    end
  end

endmodule

// File: tb/tb_text_pane_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a queue-based model of the plane operations each accepted character implies.
module tb_text_pane_scheduler;

  localparam int ROWS = 7;
  localparam int COLS = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic       v0, v1;
  logic [7:0] c0, c1;
  logic       req0_ready, req1_ready, wr_en, scroll, busy;
  logic [3:0] wr_row, cur_row;
  logic [5:0] wr_col, cur_col;
  logic [7:0] wr_char;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_wr;
    int         row;
    int         col;
    logic [7:0] ch;
  } act_t;

  act_t q[$];
  int   m_row, m_col, m_last;

  text_pane_scheduler #(.ROWS(ROWS), .COLS(COLS), .ROW_BITS(4), .COL_BITS(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (v0),
    .req0_char  (c0),
    .req0_ready (req0_ready),
    .req1_valid (v1),
    .req1_char  (c1),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .scroll     (scroll),
    .busy       (busy),
    .cur_row    (cur_row),
    .cur_col    (cur_col)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic act_t mk(input bit is_wr, input int r, input int c, input logic [7:0] ch);
    act_t a;
    a.is_wr = is_wr; a.row = r; a.col = c; a.ch = ch;
    return a;
  endfunction

  // Model: what the plane sees for one accepted character, from the rules.
  task automatic model_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      q.push_back(mk(1, m_row, m_col, ch));
      if (m_col < COLS - 1) m_col++;
      else begin
        m_col = 0;
        if (m_row < ROWS - 1) m_row++;
        else q.push_back(mk(0, 0, 0, 8'h00));
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
      if (m_row < ROWS - 1) m_row++;
      else q.push_back(mk(0, 0, 0, 8'h00));
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        q.push_back(mk(1, m_row, m_col, 8'h20));
      end
    end else if (ch == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          q.push_back(mk(1, r, c, 8'h20));
      m_row = 0;
      m_col = 0;
    end
  endtask

  // One clock: compare at the falling edge, then advance the model.
  task automatic tick(output bit acc0, output bit acc1);
    act_t a;
    bit   e0, e1;
    @(negedge clk);
    acc0 = 0;
    acc1 = 0;
    if (reset) begin
      check("rst_wr_en", wr_en, 0);
      check("rst_scroll", scroll, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", {req0_ready, req1_ready}, 0);
      check("rst_wr_bus", {wr_row, wr_col, wr_char}, 0);
      q.delete();
      m_row = 0; m_col = 0; m_last = 1;
    end else if (q.size() != 0) begin
      a = q.pop_front();
      check("busy_hi", busy, 1);
      check("ready_held", {req0_ready, req1_ready}, 0);
      check("wr_en", wr_en, a.is_wr);
      check("scroll", scroll, !a.is_wr);
      if (a.is_wr) begin
        check("wr_row", wr_row, a.row);
        check("wr_col", wr_col, a.col);
        check("wr_char", wr_char, a.ch);
      end
    end else begin
      check("idle_busy", busy, 0);
      check("idle_wr_en", wr_en, 0);
      check("idle_scroll", scroll, 0);
      check("cur_row", cur_row, m_row);
      check("cur_col", cur_col, m_col);
      e0 = v0 && (!v1 || m_last == 1);
      e1 = v1 && (!v0 || m_last == 0);
      check("ready0", req0_ready, e0);
      check("ready1", req1_ready, e1);
      if (e0) begin
        m_last = 0; acc0 = 1; model_char(c0);
      end else if (e1) begin
        m_last = 1; acc1 = 1; model_char(c1);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit a0, a1;
    reset = 1;
    v0 = 0; v1 = 0;
    tick(a0, a1);
    tick(a0, a1);
    reset = 0;
  endtask

  task automatic send_accept(input int who, input logic [7:0] ch);
    bit a0, a1, got;
    int n;
    got = 0;
    n = 0;
    if (who == 0) begin v0 = 1; c0 = ch; end
    else          begin v1 = 1; c1 = ch; end
    while (!got && n < 300) begin
      tick(a0, a1);
      if (a0) v0 = 0;
      if (a1) v1 = 0;
      got = (who == 0) ? a0 : a1;
      n++;
    end
    check("accept_timeout", got, 1);
  endtask

  task automatic drain();
    bit a0, a1;
    int n;
    n = 0;
    while ((q.size() != 0 || v0 || v1) && n < 2000) begin
      tick(a0, a1);
      if (a0) v0 = 0;
      if (a1) v1 = 0;
      n++;
    end
    check("drain_timeout", (q.size() == 0) && !v0 && !v1, 1);
  endtask

  task automatic send(input int who, input logic [7:0] ch);
    send_accept(who, ch);
    drain();
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    logic [7:0] odd [4];
    odd[0] = 8'h00; odd[1] = 8'h7F; odd[2] = 8'h1B; odd[3] = 8'h0A;
    r = $urandom_range(0, 99);
    if (r < 70)      return 8'($urandom_range(32, 126));
    else if (r < 80) return 8'h0D;
    else if (r < 90) return 8'h08;
    else if (r < 92) return 8'h0C;
    else             return odd[$urandom_range(0, 3)];
  endfunction

  initial begin
    bit a0, a1;
    int prev, g, n, who;
    c0 = 0; c1 = 0;
    do_reset();

    // First character lands at (0,0) and moves the cursor to (0,1).
    send(0, 8'h41);
    check("first_cursor", {cur_row, cur_col}, {4'd0, 6'd1});

    // Both requesters always valid: grants alternate, requester 0 first.
    do_reset();
    v0 = 1; c0 = 8'h78; v1 = 1; c1 = 8'h79;
    prev = -1; g = 0; n = 0;
    while (g < 10 && n < 100) begin
      tick(a0, a1);
      if (a0 || a1) begin
        who = a1 ? 1 : 0;
        if (prev < 0) check("rr_first", who, 0);
        else          check("rr_alternate", who, 1 - prev);
        prev = who;
        g++;
      end
      n++;
    end
    check("rr_grants", g, 10);
    v0 = 0; v1 = 0;
    drain();

    // Last cell of the plane: write then scroll, cursor (6,0).
    do_reset();
    for (int i = 0; i < ROWS - 1; i++) send(1, 8'h0D);
    for (int i = 0; i < COLS - 1; i++) send(0, 8'h2E);
    check("corner_pos", {cur_row, cur_col}, {4'd6, 6'd19});
    send(0, 8'h5A);
    check("corner_after", {cur_row, cur_col, busy}, {4'd6, 6'd0, 1'b0});

    // Backspace at (3,5), then down to column 0 and one no-op backspace.
    do_reset();
    for (int i = 0; i < 3; i++) send(0, 8'h0D);
    for (int i = 0; i < 5; i++) send(1, 8'h6B);
    send(0, 8'h08);
    check("bs_cursor", {cur_row, cur_col}, {4'd3, 6'd4});
    for (int i = 0; i < 4; i++) send(1, 8'h08);
    send(0, 8'h08);
    check("bs_noop", {cur_row, cur_col}, {4'd3, 6'd0});

    // Full clear with requester 1 waiting throughout; it is served afterwards.
    send(0, 8'h51);
    send_accept(0, 8'h0C);
    v1 = 1; c1 = 8'h71;
    drain();
    check("clear_then_q", {cur_row, cur_col}, {4'd0, 6'd1});

    // Reset in cycle 50 of a clear aborts it; next char goes to (0,0).
    send(0, 8'h0D);
    send_accept(0, 8'h0C);
    for (int i = 0; i < 49; i++) tick(a0, a1);
    reset = 1;
    tick(a0, a1);
    reset = 0;
    send(0, 8'h42);
    check("abort_cursor", {cur_row, cur_col}, {4'd0, 6'd1});

    // Random traffic from both feeds, each holding its char until accepted.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!v0 && $urandom_range(0, 1) == 1) begin v0 = 1; c0 = rand_char(); end
      if (!v1 && $urandom_range(0, 1) == 1) begin v1 = 1; c1 = rand_char(); end
      tick(a0, a1);
      if (a0) v0 = 0;
      if (a1) v1 = 0;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/text_pane_scheduler.md
TEXT_PANE_SCHEDULER -- requirements
Module: text_pane_scheduler

Interface
REQ-001 Parameter ROWS, default 7, meaning number of text lines in the character plane.
REQ-002 Parameter COLS, default 20, meaning characters per line.
REQ-003 Parameter ROW_BITS, default 4, meaning width of row fields, at least ceil(log2(ROWS)).
REQ-004 Parameter COL_BITS, default 6, meaning width of column fields, at least ceil(log2(COLS)).
REQ-005 clk  in  1  system clock; the block has one clock, and every register SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req0_valid  in  1  requester 0 (local keyboard feed) offers a character.
REQ-008 req0_char  in  8  requester 0 character code.
REQ-009 req0_ready  out  1  requester 0 character accepted this cycle.
REQ-010 req1_valid, req1_char, req1_ready  in/in/out  1/8/1  requester 1 (remote/serial feed), same meaning as REQ-007 to REQ-009.
REQ-011 wr_en  out  1  character plane write strobe.
REQ-012 wr_row  out  ROW_BITS  plane write row.
REQ-013 wr_col  out  COL_BITS  plane write column.
REQ-014 wr_char  out  8  plane write data.
REQ-015 scroll  out  1  one-cycle pulse that shifts the plane up one line and blanks the bottom line.
REQ-016 busy  out  1  high whenever the state is not IDLE.
REQ-017 cur_row, cur_col  out  ROW_BITS/COL_BITS  current cursor position.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, SCROLL and CLEAR; all outputs other than the readys SHALL be decoded from registered state and registers.
REQ-019 Ready rules:
- readys are low outside IDLE;
- in IDLE, at most one ready is high per cycle;
- transfer occurs when valid and ready are both high.
REQ-020 Arbitration SHALL be round-robin:
- with both valid, ready goes to the requester not granted last;
- with one valid, that requester gets ready;
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-021 On transfer, the character SHALL be latched and the next state chosen by code:
- 0x20-0x7E goes to WRITE;
- 0x0D goes to newline handling;
- 0x08 goes to backspace handling;
- 0x0C goes to CLEAR;
- any other code is consumed and the FSM stays in IDLE.
REQ-022 WRITE SHALL last 1 cycle and drive wr_en=1 with the cursor and latched char; wr_en is high in the cycle after the transfer edge.
REQ-023 After WRITE, the cursor advances as follows:
- if col<COLS-1, col+1 and go to IDLE;
- otherwise col=0, then row+1 and IDLE if row<ROWS-1, else row stays ROWS-1 and go to SCROLL.
REQ-024 Newline SHALL set col=0, then increment row and return to IDLE if row<ROWS-1; otherwise it goes to SCROLL with row unchanged. It generates no write.
REQ-025 Backspace:
- with col>0, col decrements and the FSM enters WRITE with char 0x20 at the new column, without advancing afterwards;
- with col=0, it is a no-op (the FSM stays in IDLE).
REQ-026 SCROLL SHALL last 1 cycle, drive scroll=1, and return to IDLE.
REQ-027 CLEAR SHALL write 0x20 to every cell in row-major order, one cell per cycle (ROWS*COLS cycles), then set the cursor to (0,0) and return to IDLE.
REQ-028 wr_en and scroll SHALL never be high in the same cycle.
REQ-029 New requests arriving during any non-IDLE state SHALL be held off (readys low), never dropped.

Reset
REQ-030 Reset SHALL force state IDLE, cursor (0,0), clear-sweep counter 0, last_grant 1, and latched char 0x00.
REQ-031 During reset, wr_en, scroll, busy, both readys, wr_row, wr_col and wr_char SHALL all be 0.
REQ-032 Reset asserted mid-CLEAR or mid-SCROLL SHALL abort immediately, with no further writes or scroll pulses.

Structure
REQ-033 A shared package SHALL hold the state enum, the ROWS/COLS/ROW_BITS/COL_BITS defaults, and the char constants 0x08, 0x0C, 0x0D and 0x20.
REQ-034 One sub-module, rr_arbiter2 (2-way round-robin grant with last_grant register), SHALL be instantiated; the cursor and FSM logic stay in the top module.

Verification
REQ-035 After reset, req0 sends 'A' (0x41): req0_ready high for 1 cycle, then wr_en=1 with row 0, col 0, char 0x41 on the next cycle, and cursor becomes (0,1).
REQ-036 Both valid continuously with 'x' and 'y': grants alternate req0, req1, req0, ..., with no requester getting two consecutive grants.
REQ-037 Cursor at (6,19), write 'Z': wr_en at (6,19), then scroll=1 the next cycle, cursor (6,0), busy low after.
REQ-038 Cursor at (3,5), send 0x08: wr_en at (3,4) with 0x20 and cursor (3,4); then send 0x08 at (3,0): no wr_en and cursor unchanged.
REQ-039 Send 0x0C: exactly 140 consecutive wr_en cycles covering (0,0) to (6,19) with 0x20, both readys low throughout, then cursor (0,0).
REQ-040 Reset asserted at cycle 50 of a CLEAR: wr_en drops the same cycle, busy 0, and the next 'B' writes at (0,0).
